// File: rtl/morse_transmit_word_pkg.sv
// Shared constants, state encoding and Morse codebook helpers for the word transmitter.
// Character codes are ASCII: 'A'-'Z' and '0'-'9' are keyable, 0 marks an empty slot.
package morse_transmit_word_pkg;

  localparam int CHAR_W        = 8;
  localparam int MAX_CHARS     = 4;
  localparam int PULSE_CNT_W   = 8;
  localparam int MORSE_LEN_W   = 3;
  localparam int MAX_MORSE_LEN = 5;
  localparam int CHAR_IDX_W    = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_GAP_ELEM,
    S_GAP_CHAR,
    S_GAP_WORD,
    S_ERROR,
    S_EMPTY
  } tx_state_t;

  typedef struct packed {
    logic [MORSE_LEN_W-1:0]   len;
    logic [MAX_MORSE_LEN-1:0] dits_dahs;
  } morse_code_t;

  // Patterns are written as read aloud (first element in the MSB of the used bits, 1 = dah)
  // and turned around so that element 0 lands in bit 0.
  function automatic morse_code_t mk_code(input logic [MORSE_LEN_W-1:0] len,
                                          input logic [MAX_MORSE_LEN-1:0] pat);
    morse_code_t c;
    c.len       = len;
    c.dits_dahs = '0;
    for (int i = 0; i < MAX_MORSE_LEN; i++) begin
      if (i < int'(len)) c.dits_dahs[i] = pat[int'(len) - 1 - i];
    end
    return c;
  endfunction

endpackage

// File: rtl/morse_encode_char.sv
// Combinational codebook: character code -> element count and dit/dah pattern.
// Unknown codes (and the empty code 0) return len = 0.
module morse_encode_char
  import morse_transmit_word_pkg::*;
(
  input  logic [CHAR_W-1:0]        code,
  output logic [MORSE_LEN_W-1:0]   len,
  output logic [MAX_MORSE_LEN-1:0] dits_dahs
);

  morse_code_t c;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    c = '0;
    case (code)
      8'h41: c = mk_code(3'd2, 5'b00001); // A .-
      8'h42: c = mk_code(3'd4, 5'b01000); // B -...
      8'h43: c = mk_code(3'd4, 5'b01010); // C -.-.
      8'h44: c = mk_code(3'd3, 5'b00100); // D -..
      8'h45: c = mk_code(3'd1, 5'b00000); // E .
      8'h46: c = mk_code(3'd4, 5'b00010); // F ..-.
      8'h47: c = mk_code(3'd3, 5'b00110); // G --.
      8'h48: c = mk_code(3'd4, 5'b00000); // H ....
      8'h49: c = mk_code(3'd2, 5'b00000); // I ..
      8'h4A: c = mk_code(3'd4, 5'b00111); // J .---
      8'h4B: c = mk_code(3'd3, 5'b00101); // K -.-
      8'h4C: c = mk_code(3'd4, 5'b00100); // L .-..
      8'h4D: c = mk_code(3'd2, 5'b00011); // M --
      8'h4E: c = mk_code(3'd2, 5'b00010); // N -.
      8'h4F: c = mk_code(3'd3, 5'b00111); // O ---
      8'h50: c = mk_code(3'd4, 5'b00110); // P .--.
      8'h51: c = mk_code(3'd4, 5'b01101); // Q --.-
      8'h52: c = mk_code(3'd3, 5'b00010); // R .-.
      8'h53: c = mk_code(3'd3, 5'b00000); // S ...
      8'h54: c = mk_code(3'd1, 5'b00001); // T -
      8'h55: c = mk_code(3'd3, 5'b00001); // U ..-
      8'h56: c = mk_code(3'd4, 5'b00001); // V ...-
      8'h57: c = mk_code(3'd3, 5'b00011); // W .--
      8'h58: c = mk_code(3'd4, 5'b01001); // X -..-
      8'h59: c = mk_code(3'd4, 5'b01011); // Y -.--
      8'h5A: c = mk_code(3'd4, 5'b01100); // Z --..
      8'h30: c = mk_code(3'd5, 5'b11111); // 0
      8'h31: c = mk_code(3'd5, 5'b01111); // 1
      8'h32: c = mk_code(3'd5, 5'b00111); // 2
      8'h33: c = mk_code(3'd5, 5'b00011); // 3
      8'h34: c = mk_code(3'd5, 5'b00001); // 4
      8'h35: c = mk_code(3'd5, 5'b00000); // 5
      8'h36: c = mk_code(3'd5, 5'b10000); // 6
      8'h37: c = mk_code(3'd5, 5'b11000); // 7
      8'h38: c = mk_code(3'd5, 5'b11100); // 8
      8'h39: c = mk_code(3'd5, 5'b11110); // 9
      default: c = '0;
    endcase
  end

  assign len       = c.len;
  assign dits_dahs = c.dits_dahs;

endmodule

// File: rtl/morse_transmit_word.sv
// Keys a word of character codes as Morse on/off timing, counted in ce ticks.
// Optional build macro MORSE_TX_ABORT_EN adds an abort input that ends a transmission early.
module morse_transmit_word
  import morse_transmit_word_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic [PULSE_CNT_W-1:0]      dit_time,
  input  logic [PULSE_CNT_W-1:0]      dah_time,
  input  logic [PULSE_CNT_W-1:0]      word_time,
  input  logic [CHAR_W*MAX_CHARS-1:0] word,
  input  logic                        start,
`ifdef MORSE_TX_ABORT_EN
  input  logic                        abort,
`endif
  output logic                        busy,
  output logic                        signal,
  output logic                        done,
  output logic                        error
);

  tx_state_t                   state_q, state_d;
  logic [PULSE_CNT_W-1:0]      cnt_q, cnt_d, dur, dur_eff, cnt_inc;
  logic [CHAR_IDX_W-1:0]       char_q, char_d, char_nxt;
  logic [MORSE_LEN_W-1:0]      elem_q, elem_d;
  logic [CHAR_W*MAX_CHARS-1:0] word_q;
  logic [PULSE_CNT_W-1:0]      dit_q, dah_q, wgap_q;
  logic [CHAR_W-1:0]           slots [MAX_CHARS];
  logic [CHAR_W-1:0]           enc_code;
  logic [MORSE_LEN_W-1:0]      enc_len;
  logic [MAX_MORSE_LEN-1:0]    enc_dd;
  logic                        last, has_next, accept, abort_in, abort_hit;
  logic                        busy_d, done_d, error_d;

`ifdef MORSE_TX_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif
  assign abort_hit = abort_in & busy;

  always_comb begin
    for (int i = 0; i < MAX_CHARS; i++) slots[i] = word_q[i*CHAR_W +: CHAR_W];
  end

  // While idle the lookup looks at the live input so slot 0 can be judged on the accepting edge.
  assign enc_code = (state_q == S_IDLE) ? word[CHAR_W-1:0] : slots[char_q];

  morse_encode_char u_encode (
    .code      (enc_code),
    .len       (enc_len),
    .dits_dahs (enc_dd)
  );

  always_comb begin
    dur = dit_q;
    case (state_q)
      S_MARK:     dur = enc_dd[elem_q] ? dah_q : dit_q;
      S_GAP_ELEM: dur = dit_q;
      S_GAP_CHAR: dur = dah_q;
      S_GAP_WORD: dur = wgap_q;
      default:    dur = dit_q;
    endcase
  end

  assign dur_eff  = (dur == '0) ? PULSE_CNT_W'(1) : dur;
  assign last     = (cnt_q >= dur_eff - PULSE_CNT_W'(1));
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + PULSE_CNT_W'(1);
  assign char_nxt = char_q + CHAR_IDX_W'(1);
  assign has_next = (char_q != CHAR_IDX_W'(MAX_CHARS - 1)) && (slots[char_nxt] != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    elem_d  = elem_q;
    busy_d  = busy;
    done_d  = 1'b0;
    error_d = 1'b0;
    accept  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort_in) begin
          accept = 1'b1;
          busy_d = 1'b1;
          cnt_d  = '0;
          char_d = '0;
          elem_d = '0;
          if (word[CHAR_W-1:0] == '0) state_d = S_EMPTY;
          else if (enc_len == '0)     state_d = S_ERROR;
          else                        state_d = S_MARK;
        end
      end
      S_MARK: begin
        if (last) begin
          cnt_d = '0;
          if ((elem_q + MORSE_LEN_W'(1)) < enc_len) begin
            state_d = S_GAP_ELEM;
          end else if (has_next) begin
            state_d = S_GAP_CHAR;
            char_d  = char_nxt;
            elem_d  = '0;
          end else begin
            state_d = S_GAP_WORD;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP_ELEM: begin
        if (last) begin
          cnt_d   = '0;
          state_d = S_MARK;
          if (elem_q < MORSE_LEN_W'(MAX_MORSE_LEN - 1)) elem_d = elem_q + MORSE_LEN_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP_CHAR: begin
        if (last) begin
          cnt_d   = '0;
          elem_d  = '0;
          state_d = (enc_len == '0) ? S_ERROR : S_MARK;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP_WORD: begin
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ERROR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        error_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_EMPTY: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides whatever the FSM was about to do this tick.
    if (abort_hit) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      char_d  = '0;
      elem_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      char_q  <= '0;
      elem_q  <= '0;
      word_q  <= '0;
      dit_q   <= '0;
      dah_q   <= '0;
      wgap_q  <= '0;
      busy    <= 1'b0;
      signal  <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      done  <= 1'b0;
      error <= 1'b0;
      if (ce) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        char_q  <= char_d;
        elem_q  <= elem_d;
        busy    <= busy_d;
        signal  <= (state_d == S_MARK);
        done    <= done_d;
        error   <= error_d;
        if (accept) begin
          word_q <= word;
          dit_q  <= dit_time;
          dah_q  <= dah_time;
          wgap_q <= word_time;
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_transmit_word.sv
// Directed bench for morse_transmit_word: keyed waveforms are compared against hand-built traces.
module tb_morse_transmit_word;
  import morse_transmit_word_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        ce;
  logic [PULSE_CNT_W-1:0]      dit_time, dah_time, word_time;
  logic [CHAR_W*MAX_CHARS-1:0] word;
  logic                        start;
  logic                        busy, signal, done, error;
`ifdef MORSE_TX_ABORT_EN
  logic                        abort = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] exp_tr;
  int           exp_pos;

  logic [255:0] tr;
  int           done_at, ndone;
  logic         err_at, busy0, busy_end;

  morse_transmit_word dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .dit_time  (dit_time),
    .dah_time  (dah_time),
    .word_time (word_time),
    .word      (word),
    .start     (start),
`ifdef MORSE_TX_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .signal    (signal),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic exp_clear();
    exp_tr  = '0;
    exp_pos = 0;
  endtask

  task automatic put(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_pos < 256) exp_tr[exp_pos] = level;
      exp_pos++;
    end
  endtask

  task automatic set_times(input int d, input int h, input int w);
    dit_time  = PULSE_CNT_W'(d);
    dah_time  = PULSE_CNT_W'(h);
    word_time = PULSE_CNT_W'(w);
  endtask

  // Records signal per clock edge; edge 0 is the accepting edge. Optionally pokes
  // start/word/dit_time mid-run to show they are ignored while busy.
  task automatic send(input logic [CHAR_W*MAX_CHARS-1:0] w, input int div, input int budget,
                      input int poke_at);
    logic [PULSE_CNT_W-1:0] dit_save;
    dit_save = dit_time;
    tr = '0; done_at = -1; ndone = 0; err_at = 1'b0; busy0 = 1'b0; busy_end = 1'b1;
    word  = w;
    start = 1'b1;
    for (int c = 0; c < budget; c++) begin
      ce = ((c % div) == 0);
      if (poke_at >= 0 && c == poke_at) begin
        start    = 1'b1;
        word     = 32'h0000_0054;
        dit_time = PULSE_CNT_W'(9);
      end
      if (poke_at >= 0 && c == poke_at + 1) start = 1'b0;
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b0;
        busy0 = busy;
      end
      if (c < 256) tr[c] = signal;
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at  = c;
          err_at   = error;
          busy_end = busy;
        end
      end
      if (done_at >= 0 && c >= done_at + 3) break;
    end
    ce       = 1'b1;
    start    = 1'b0;
    dit_time = dit_save;
  endtask

  task automatic check_run(input string tag, input int want_done, input logic want_err);
    check({tag, "_trace"}, tr, exp_tr);
    check({tag, "_done_at"}, 256'(done_at), 256'(want_done));
    check({tag, "_error"}, 256'(err_at), 256'(want_err));
    check({tag, "_ndone"}, 256'(ndone), 256'(1));
    check({tag, "_busy0"}, 256'(busy0), 256'(1));
    check({tag, "_busy_end"}, 256'(busy_end), 256'(0));
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; start = 1'b0; word = '0;
    set_times(2, 6, 14);
    repeat (3) @(posedge clk);
    #1;
    check("reset_signal", 256'(signal), 256'(0));
    check("reset_busy",   256'(busy),   256'(0));
    check("reset_done",   256'(done),   256'(0));
    check("reset_error",  256'(error),  256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "E"
    send(32'h0000_0045, 1, 60, -1);
    exp_clear(); put(1, 2); put(0, 14);
    check_run("E", 16, 1'b0);

    // "ET"
    send(32'h0000_5445, 1, 60, -1);
    exp_clear(); put(1, 2); put(0, 6); put(1, 6); put(0, 14);
    check_run("ET", 28, 1'b0);

    // "SOS" with a start/word/dit_time poke partway through the O
    send(32'h0053_4F53, 1, 120, 20);
    exp_clear();
    put(1, 2); put(0, 2); put(1, 2); put(0, 2); put(1, 2); put(0, 6);
    put(1, 6); put(0, 2); put(1, 6); put(0, 2); put(1, 6); put(0, 6);
    put(1, 2); put(0, 2); put(1, 2); put(0, 2); put(1, 2); put(0, 14);
    check_run("SOS_poked", 68, 1'b0);

    // All four slots used
    send(32'h4545_4545, 1, 80, -1);
    exp_clear();
    for (int i = 0; i < 3; i++) begin put(1, 2); put(0, 6); end
    put(1, 2); put(0, 14);
    check_run("EEEE", 40, 1'b0);

    // Zero slot ends the word; the T after it is never sent
    send(32'h0054_0045, 1, 60, -1);
    exp_clear(); put(1, 2); put(0, 14);
    check_run("E_gap_T", 16, 1'b0);

    // Invalid code in slot 1
    send(32'h0000_2345, 1, 40, -1);
    exp_clear(); put(1, 2); put(0, 7);
    check_run("E_bad", 9, 1'b1);

    // Invalid code in slot 0
    send(32'h0000_0023, 1, 20, -1);
    exp_clear();
    check_run("bad_first", 1, 1'b1);

    // Empty word
    send(32'h0000_0000, 1, 20, -1);
    exp_clear();
    check_run("empty", 1, 1'b0);

    // Zero durations behave as one tick
    set_times(0, 0, 0);
    send(32'h0000_0045, 1, 20, -1);
    exp_clear(); put(1, 1); put(0, 1);
    check_run("E_zero_times", 2, 1'b0);

    // "A" with dit=1, dah=3, word=7
    set_times(1, 3, 7);
    send(32'h0000_0041, 1, 30, -1);
    exp_clear(); put(1, 1); put(0, 1); put(1, 3); put(0, 7);
    check_run("A_137", 12, 1'b0);

    // ce on every third clock stretches everything by 3
    set_times(2, 6, 14);
    send(32'h0000_0045, 3, 80, -1);
    exp_clear(); put(1, 6); put(0, 42);
    check_run("E_ce_div3", 48, 1'b0);

    // Reset during a dah, then a clean transmission
    word = 32'h0000_0054; start = 1'b1; ce = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("T_mid_dah_signal", 256'(signal), 256'(1));
    rst_n = 1'b0;
    #1;
    check("rst_signal_async", 256'(signal), 256'(0));
    check("rst_busy_async",   256'(busy),   256'(0));
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rst_no_done", 256'(ndone), 256'(0));
    send(32'h0000_0045, 1, 60, -1);
    exp_clear(); put(1, 2); put(0, 14);
    check_run("E_after_rst", 16, 1'b0);

`ifdef MORSE_TX_ABORT_EN
    // Abort during a mark
    word = 32'h0000_0054; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_signal", 256'(signal), 256'(0));
    check("abort_done",   256'(done),   256'(1));
    check("abort_error",  256'(error),  256'(0));
    check("abort_busy",   256'(busy),   256'(0));
    // Abort beats a simultaneous start while idle
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("abort_idle_busy", 256'(busy), 256'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
